// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state, class, alu_op and opcode constants for the LEGv8 multi-cycle sequencer
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_CBNZ    = 3'd5,
    CLS_B       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } cls_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS  = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction/data memory request and ready handshake
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_read;
  logic dmem_write;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_read,
    output dmem_write,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_read,
    input  dmem_write,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_control_opcode_classifier.sv
// rtl/multicycle_control_opcode_classifier.sv - maps IR[31:21] to the instruction class
module opcode_classifier
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output cls_e        cls
);

  // I-format uses a 10-bit opcode, CB 8-bit and B 6-bit, so the low bits are don't-care.
  always_comb begin
    cls = CLS_ILLEGAL;
    casez (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR:           cls = CLS_R;
      11'b1001000100?, 11'b1001001000?,
      11'b1101001000?, 11'b1011001000?,
      11'b1101000100?:                          cls = CLS_I;
      OP_LDUR, OP_LDURB, OP_LDURH, OP_LDURSW:   cls = CLS_LOAD;
      OP_STUR, OP_STURB, OP_STURH, OP_STURW:    cls = CLS_STORE;
      11'b10110100???:                          cls = CLS_CBZ;
      11'b10110101???:                          cls = CLS_CBNZ;
      11'b000101?????:                          cls = CLS_B;
      default:                                  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multi-cycle control FSM with memory watchdog and retire counter
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int COUNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [10:0]          opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 readreg2_control,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic [2:0]           state_out,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [COUNT_W-1:0]   instr_count
);

  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  state_e            state;
  cls_e              cls;
  cls_e              dec_cls;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              wd_expire;
  logic              imem_req;
  logic              dmem_read;
  logic              dmem_write;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (dec_cls)
  );

  assign mem_wait  = ((state == ST_FETCH) && !mem.imem_ready) ||
                     ((state == ST_MEM)   && !mem.dmem_ready);
  // Expiry only fires while ready is low, so ready on the last allowed cycle proceeds.
  assign wd_expire = (WAIT_LIMIT != 0) && mem_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cls         <= CLS_ILLEGAL;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      if (instr_done)
        instr_count <= instr_count + COUNT_W'(1);

      if (mem_wait && !wd_expire && (WAIT_LIMIT != 0))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;

      case (state)
        ST_IDLE: begin
          if (start)
            state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem.imem_ready) begin
            state <= ST_DECODE;
          end else if (wd_expire) begin
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == CLS_ILLEGAL) begin
            illegal <= 1'b1;
            state   <= ST_FETCH;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (cls)
            CLS_R, CLS_I:        state <= ST_WRITEBACK;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem.dmem_ready) begin
            state <= (cls == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
          end else if (wd_expire) begin
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WRITEBACK: state <= ST_FETCH;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are forced low while reset is high so an abandoned instruction never commits.
  always_comb begin
    imem_req         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    mem_to_reg       = 1'b0;
    reg_write        = 1'b0;
    readreg2_control = 1'b0;
    alu_src          = 1'b0;
    alu_op           = ALU_ADD;
    instr_done       = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = mem.imem_ready;
        end
        ST_DECODE: begin
          pc_write = (dec_cls == CLS_ILLEGAL);
        end
        ST_EXECUTE: begin
          case (cls)
            CLS_R: alu_op = ALU_FUNCT;
            CLS_I: begin
              alu_src = 1'b1;
              alu_op  = ALU_FUNCT;
            end
            CLS_LOAD: alu_src = 1'b1;
            CLS_STORE: begin
              alu_src          = 1'b1;
              readreg2_control = 1'b1;
            end
            CLS_CBZ, CLS_CBNZ: begin
              alu_op           = ALU_PASS;
              readreg2_control = 1'b1;
              pc_write         = 1'b1;
              instr_done       = 1'b1;
              pc_src           = (cls == CLS_CBZ) ? zero : !zero;
            end
            CLS_B: begin
              alu_op     = ALU_PASS;
              pc_write   = 1'b1;
              instr_done = 1'b1;
              pc_src     = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_read  = (cls == CLS_LOAD);
          dmem_write = (cls == CLS_STORE);
          if ((cls == CLS_STORE) && mem.dmem_ready) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == CLS_LOAD);
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.imem_req   = imem_req;
  assign mem.dmem_read  = dmem_read;
  assign mem.dmem_write = dmem_write;
  assign state_out      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] opcode;
  logic        zero;
  logic        ir_write, pc_write, pc_src, mem_to_reg, reg_write;
  logic        readreg2_control, alu_src, instr_done, illegal, bus_error;
  logic [1:0]  alu_op;
  logic [2:0]  state_out;
  logic [2:0]  instr_count;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc_no = 0;
  int t0     = 0;
  int rd_hi  = 0;

  always #5 clk = ~clk;

  multicycle_control_if mem_bus ();

  multicycle_control #(
    .WAIT_LIMIT (4),
    .COUNT_W    (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .opcode           (opcode),
    .zero             (zero),
    .mem              (mem_bus),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .mem_to_reg       (mem_to_reg),
    .reg_write        (reg_write),
    .readreg2_control (readreg2_control),
    .alu_src          (alu_src),
    .alu_op           (alu_op),
    .state_out        (state_out),
    .instr_done       (instr_done),
    .illegal          (illegal),
    .bus_error        (bus_error),
    .instr_count      (instr_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    zero  = 1'b0;
    opcode = 11'h000;
    mem_bus.imem_ready = 1'b1;
    mem_bus.dmem_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_state", state_out, 0);
    chk("rst_imem_req", mem_bus.imem_req, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_bus_error", bus_error, 0);

    // ADD, ready always high
    reset  = 1'b0;
    opcode = 11'h458;
    start  = 1'b1;
    #1;
    chk("add_idle_before_edge", state_out, 0);
    cyc();
    start = 1'b0;
    chk("add_c1_state", state_out, 1);
    chk("add_c1_imem_req", mem_bus.imem_req, 1);
    chk("add_c1_ir_write", ir_write, 1);
    cyc();
    chk("add_c2_state", state_out, 2);
    chk("add_c2_pc_write", pc_write, 0);
    cyc();
    chk("add_c3_state", state_out, 3);
    chk("add_c3_alu_op", alu_op, 2);
    chk("add_c3_alu_src", alu_src, 0);
    chk("add_c3_reg_write", reg_write, 0);
    cyc();
    chk("add_c4_state", state_out, 5);
    chk("add_c4_reg_write", reg_write, 1);
    chk("add_c4_mem_to_reg", mem_to_reg, 0);
    chk("add_c4_pc_write", pc_write, 1);
    chk("add_c4_instr_done", instr_done, 1);
    cyc();
    chk("add_c5_state", state_out, 1);
    chk("add_c5_reg_write", reg_write, 0);
    chk("add_count", instr_count, 1);

    // LDUR with dmem_ready arriving on the 4th MEM cycle
    opcode = 11'h7C2;
    mem_bus.dmem_ready = 1'b0;
    t0 = cyc_no;
    cyc();
    chk("ld_decode", state_out, 2);
    cyc();
    chk("ld_exec_state", state_out, 3);
    chk("ld_exec_alu_src", alu_src, 1);
    chk("ld_exec_alu_op", alu_op, 0);
    rd_hi = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) mem_bus.dmem_ready = 1'b1;
      #1;
      chk("ld_mem_state", state_out, 4);
      chk("ld_mem_reg_write", reg_write, 0);
      rd_hi += int'(mem_bus.dmem_read);
    end
    chk("ld_dmem_read_cycles", rd_hi, 4);
    cyc();
    chk("ld_wb_state", state_out, 5);
    chk("ld_wb_reg_write", reg_write, 1);
    chk("ld_wb_mem_to_reg", mem_to_reg, 1);
    chk("ld_wb_pc_write", pc_write, 1);
    cyc();
    chk("ld_back_fetch", state_out, 1);
    chk("ld_latency", cyc_no - t0, 8);
    chk("ld_count", instr_count, 2);

    // CBZ taken, start ignored mid-instruction
    opcode = 11'h5A0;
    zero   = 1'b1;
    cyc();
    chk("cbz_decode", state_out, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("cbz_exec_state", state_out, 3);
    chk("cbz_pc_src", pc_src, 1);
    chk("cbz_pc_write", pc_write, 1);
    chk("cbz_instr_done", instr_done, 1);
    chk("cbz_reg_write", reg_write, 0);
    chk("cbz_alu_op", alu_op, 1);
    chk("cbz_rr2", readreg2_control, 1);
    cyc();
    chk("cbz_fetch", state_out, 1);
    chk("cbz_count", instr_count, 3);

    // CBNZ with zero=1 not taken
    opcode = 11'h5A8;
    cyc();
    cyc();
    chk("cbnz_exec_state", state_out, 3);
    chk("cbnz_pc_src", pc_src, 0);
    chk("cbnz_pc_write", pc_write, 1);
    chk("cbnz_reg_write", reg_write, 0);
    cyc();
    chk("cbnz_count", instr_count, 4);

    // B
    opcode = 11'h0A5;
    zero   = 1'b0;
    cyc();
    cyc();
    chk("b_pc_src", pc_src, 1);
    chk("b_alu_op", alu_op, 1);
    chk("b_rr2", readreg2_control, 0);
    cyc();
    chk("b_count", instr_count, 5);

    // STUR, no wait
    opcode = 11'h7C0;
    cyc();
    cyc();
    chk("st_exec_alu_src", alu_src, 1);
    chk("st_exec_rr2", readreg2_control, 1);
    chk("st_exec_alu_op", alu_op, 0);
    cyc();
    chk("st_mem_state", state_out, 4);
    chk("st_dmem_write", mem_bus.dmem_write, 1);
    chk("st_dmem_read", mem_bus.dmem_read, 0);
    chk("st_pc_write", pc_write, 1);
    chk("st_instr_done", instr_done, 1);
    cyc();
    chk("st_fetch", state_out, 1);
    chk("st_count", instr_count, 6);

    // ADDI
    opcode = 11'h489;
    cyc();
    cyc();
    chk("addi_alu_src", alu_src, 1);
    chk("addi_alu_op", alu_op, 2);
    cyc();
    chk("addi_wb_state", state_out, 5);
    chk("addi_reg_write", reg_write, 1);
    chk("addi_mem_to_reg", mem_to_reg, 0);
    cyc();
    chk("addi_count", instr_count, 7);

    // Illegal opcode skipped without retiring
    opcode = 11'h000;
    cyc();
    chk("ill_decode", state_out, 2);
    chk("ill_pc_write", pc_write, 1);
    chk("ill_pc_src", pc_src, 0);
    chk("ill_instr_done", instr_done, 0);
    cyc();
    chk("ill_fetch", state_out, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_count", instr_count, 7);

    // One more B wraps the 3-bit counter
    opcode = 11'h0BF;
    cyc();
    cyc();
    cyc();
    chk("wrap_count", instr_count, 0);

    // Watchdog on fetch: four wait cycles then IDLE
    mem_bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_wait_state", state_out, 1);
      chk("wd_wait_bus_error", bus_error, 0);
      cyc();
    end
    chk("wd_state", state_out, 0);
    chk("wd_bus_error", bus_error, 1);
    chk("wd_imem_req", mem_bus.imem_req, 0);
    chk("wd_illegal_sticky", illegal, 1);

    // Reset during MEM of STUR
    mem_bus.imem_ready = 1'b1;
    start = 1'b1;
    cyc();
    start  = 1'b0;
    opcode = 11'h7C0;
    mem_bus.dmem_ready = 1'b0;
    chk("rm_fetch", state_out, 1);
    cyc();
    cyc();
    cyc();
    chk("rm_mem_state", state_out, 4);
    chk("rm_dmem_write", mem_bus.dmem_write, 1);
    reset = 1'b1;
    cyc();
    chk("rm_state", state_out, 0);
    chk("rm_dmem_write_off", mem_bus.dmem_write, 0);
    chk("rm_bus_error", bus_error, 0);
    chk("rm_illegal", illegal, 0);
    chk("rm_count", instr_count, 0);
    reset = 1'b0;
    mem_bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rm_after_dmem_write", mem_bus.dmem_write, 0);
      chk("rm_after_pc_write", pc_write, 0);
      chk("rm_after_state", state_out, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the LEGv8 datapath.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and emits per-state datapath strobes.
- Handles ready handshakes with instruction and data memory, applies a watchdog on memory waits, and counts retired instructions.
- Sits beside the register file, ALU and PC. Replaces single-cycle decoding when the datapath runs multi-cycle.

Parameters:
- WAIT_LIMIT, 16: max cycles waiting on imem_ready/dmem_ready before bus_error; 0 disables the watchdog.
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  11  instruction bits [31:21] from IR; valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXECUTE
- imem_ready  in  1  instruction memory has data / accepted request
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- dmem_read  out  1  data read strobe
- dmem_write  out  1  data write strobe
- mem_to_reg  out  1  write-back source is memory
- reg_write  out  1  register file write enable
- readreg2_control  out  1  read register 2 from Rt field
- alu_src  out  1  ALU B operand is the immediate
- alu_op  out  2  00 add, 01 pass/compare B, 10 funct-decoded
- state_out  out  3  current state encoding
- instr_done  out  1  one-cycle pulse per retired instruction
- illegal  out  1  sticky; unrecognised opcode seen
- bus_error  out  1  sticky; memory watchdog expired
- instr_count  out  COUNT_W  retired-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5. Moore outputs decode from state plus the latched class.
- Reset: state=IDLE. All outputs are 0, including the counters and sticky flags. Reset mid-instruction abandons the instruction with no pc_write or reg_write.
- IDLE: go to FETCH when start=1, otherwise stay.
- FETCH: imem_req=1. Hold until imem_ready=1; in that cycle ir_write=1, then go to DECODE.
- DECODE: latch opcode class, one of R (ADD/SUB/AND/ORR), I (ADDI/ANDI/EORI/ORRI/SUBI), LOAD (LDUR/LDURB/LDURH/LDURSW), STORE (STUR/STURB/STURH/STURW), CBZ, CBNZ, B, or ILLEGAL.
  - ILLEGAL: set illegal, pulse pc_write with pc_src=0, go to FETCH (instruction skipped, not counted).
- EXECUTE: drive alu_src/alu_op/readreg2_control per class.
  - R: 0/10/0. I: 1/10/0. LOAD: 1/00/0. STORE: 1/00/1. CBZ/CBNZ: 0/01/1. B: 0/01/0.
  - Branch classes finish here: pc_write=1, instr_done=1, then FETCH. pc_src=1 if B, or CBZ with zero=1, or CBNZ with zero=0.
  - R/I go to WRITEBACK; LOAD/STORE go to MEM.
- MEM: dmem_read=1 (LOAD) or dmem_write=1 (STORE), held until dmem_ready.
  - STORE: on ready, pc_write=1 (pc_src=0), instr_done=1, then FETCH.
  - LOAD: on ready, go to WRITEBACK.
- WRITEBACK: reg_write=1, mem_to_reg=1 for LOAD and 0 otherwise, pc_write=1 (pc_src=0), instr_done=1, then FETCH.
- Latency in cycles with zero wait: R/I 4, LOAD 5, STORE 4, branches 3. Each memory wait cycle adds 1.
- Watchdog: one counter counts consecutive wait cycles in FETCH or MEM and clears on state change.
  - If WAIT_LIMIT!=0 and ready is still 0 after WAIT_LIMIT wait cycles, set bus_error, drop strobes and go to IDLE.
  - Ready arriving on the limit cycle wins.
- instr_count increments on each instr_done and wraps modulo 2^COUNT_W.
- start is ignored outside IDLE. Sticky flags clear only on reset.

Decomposition:
- constants.vh (existing opcode macros): add state encodings, class encodings and alu_op encodings.
- One combinational sub-module, opcode_classifier (opcode → 3-bit class), reused by DECODE and the bench.

Test Plan:
- ADD, ready always 1, start pulse → states 1,2,3,5; reg_write=1 only in cycle 4 with mem_to_reg=0; instr_count=1.
- LDUR with dmem_ready delayed 3 cycles → dmem_read high 4 cycles; WRITEBACK has mem_to_reg=1 and reg_write=1; total 8 cycles.
- CBZ with zero=1, then CBNZ with zero=1 → first pc_src=1 and second pc_src=0; pc_write pulses in EXECUTE; no reg_write.
- opcode 11'h000 → illegal=1, pc_write with pc_src=0, instr_count unchanged, back in FETCH after DECODE.
- WAIT_LIMIT=4, imem_ready stuck 0 → bus_error=1 after 4 wait cycles, state=IDLE. Reset asserted during MEM of STUR → all outputs 0 next cycle, no dmem_write afterwards.
